// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states and the Branch/Jump encodings produced by the control decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    VALID = 2'b01,
    HALT  = 2'b10
  } fetch_state_t;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_BEQ   = 2'b01;
  localparam logic [1:0] BR_BNE   = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JR   = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_J    = 2'b11;

  // Word-aligned byte offset of a 16-bit branch immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jump outranks branch, anything unrecognised falls through to pc+4.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr,
  input  logic [1:0]  branch,
  input  logic [1:0]  jump,
  input  logic        alu_zero,
  input  logic [29:0] rs_word,
  output logic [31:0] next_pc,
  output logic [31:0] pc4
);

  assign pc4 = pc + 32'd4;

  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc4;
    case (jump)
      JMP_JR:         next_pc = {rs_word, 2'b00};
      JMP_JAL, JMP_J: next_pc = {pc4[31:28], instr, 2'b00};
      default: begin
        case (branch)
          BR_BEQ:  if (alu_zero)  next_pc = pc4 + branch_offset(instr[15:0]);
          BR_BNE:  if (!alu_zero) next_pc = pc4 + branch_offset(instr[15:0]);
          default: next_pc = pc4;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch stage with IMEM req/ack handshake and syscall halt.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_CODE = 32'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic [1:0]  branch,
  input  logic [1:0]  jump,
  input  logic        syscall_src,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] v0_data,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         halt_now;
  logic         retire;

  next_pc_calc u_next_pc_calc (
    .pc       (pc),
    .instr    (instr[25:0]),
    .branch   (branch),
    .jump     (jump),
    .alu_zero (alu_zero),
    .rs_word  (rs_data[31:2]),
    .next_pc  (next_pc),
    .pc4      (pc_plus4)
  );

  assign imem_addr = pc;
  assign halt_now  = syscall_src && (v0_data == HALT_CODE);
  assign retire    = (state == VALID) && !stall;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: instr is a single register (not a memory), so it is cleared on reset like the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b1;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (halt_now) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALT: ;
        default: begin
          instr_valid <= 1'b0;
          imem_req    <= 1'b1;
          state       <= FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Both counters freeze once halted; the retiring halt syscall still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state != HALT) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized fetch/retire traffic against a behavioural PC model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_CODE = 32'd10;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        stall;
  logic [1:0]  branch;
  logic [1:0]  jump;
  logic        syscall_src;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic [31:0] v0_data;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_pc;
  logic [31:0] model_instr;
  logic [31:0] model_retired;

  fetch_unit #(.RESET_PC(RESET_PC), .HALT_CODE(HALT_CODE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .branch      (branch),
    .jump        (jump),
    .syscall_src (syscall_src),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .v0_data     (v0_data),
    .halted      (halted),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Next PC from the ISA rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] iw,
                                           input logic [1:0] br, input logic [1:0] jmp,
                                           input logic z, input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = $signed(iw[15:0]);
    if (jmp == 2'd1) return rs & 32'hFFFF_FFFC;
    if (jmp == 2'd2 || jmp == 2'd3) return (seq & 32'hF000_0000) | (32'(iw[25:0]) * 32'd4);
    if ((br == 2'd1 && z) || (br == 2'd2 && !z)) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic fetch_instr(input logic [31:0] word, input int delay);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_req: imem_req=%b expected 1", imem_req);
    end
    checks++;
    if (imem_addr !== model_pc) begin
      errors++; $display("FAIL fetch_addr: imem_addr=%h expected %h", imem_addr, model_pc);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== model_pc) begin
        errors++;
        $display("FAIL fetch_wait: req=%b valid=%b addr=%h expected req=1 valid=0 addr=%h",
                 imem_req, instr_valid, imem_addr, model_pc);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    model_instr = word;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++; $display("FAIL fetch_valid: instr_valid=%b expected 1", instr_valid);
    end
    checks++;
    if (instr !== word) begin
      errors++; $display("FAIL fetch_instr: instr=%h expected %h", instr, word);
    end
    checks++;
    if (imem_req !== 1'b0 || pc_plus4 !== model_pc + 32'd4) begin
      errors++;
      $display("FAIL fetch_after: req=%b pc_plus4=%h expected req=0 pc_plus4=%h",
               imem_req, pc_plus4, model_pc + 32'd4);
    end
  endtask

  task automatic retire(input logic [1:0] br, input logic [1:0] jmp, input logic z,
                        input logic [31:0] rs, input logic sc, input logic [31:0] v0);
    logic [31:0] exp_pc;
    bit          halting;
    exp_pc  = ref_next(model_pc, model_instr, br, jmp, z, rs);
    halting = sc && (v0 == HALT_CODE);
    branch = br; jump = jmp; alu_zero = z; rs_data = rs; syscall_src = sc; v0_data = v0;
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    branch = 2'b00; jump = 2'b00; alu_zero = 1'b0; syscall_src = 1'b0;
    rs_data = $urandom; v0_data = $urandom_range(0, 9);
    model_retired++;
    if (halting) begin
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== model_pc) begin
        errors++;
        $display("FAIL retire_halt: halted=%b req=%b valid=%b addr=%h expected 1 0 0 %h",
                 halted, imem_req, instr_valid, imem_addr, model_pc);
      end
    end else begin
      model_pc = exp_pc;
      checks++;
      if (imem_addr !== model_pc || imem_req !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL retire_next: addr=%h req=%b valid=%b halted=%b expected addr=%h req=1 valid=0 halted=0",
                 imem_addr, imem_req, instr_valid, halted, model_pc);
      end
    end
  endtask

  task automatic jump_to(input logic [31:0] target);
    fetch_instr($urandom, 0);
    retire(BR_NONE, JMP_JR, 1'b0, target, 1'b0, 32'd0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b0 || instr !== 32'd0 ||
        cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b halted=%b instr=%h cyc=%h icnt=%h expected all 0",
               instr_valid, halted, instr, cycle_cnt, instr_cnt);
    end
    rst_n = 1'b1;
    model_pc = RESET_PC;
    model_retired = '0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_first_fetch;
    fetch_instr(32'h2008_0005, 3);
    retire(BR_NONE, JMP_NONE, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_branch;
    jump_to(32'h10);
    fetch_instr({16'($urandom), 16'hFFFE}, 1);
    retire(BR_BEQ, JMP_NONE, 1'b1, 32'd0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0C) begin
      errors++; $display("FAIL beq_taken: imem_addr=%h expected 0000000c", imem_addr);
    end
    jump_to(32'h10);
    fetch_instr({16'($urandom), 16'hFFFE}, 2);
    retire(BR_BEQ, JMP_NONE, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h14) begin
      errors++; $display("FAIL beq_not_taken: imem_addr=%h expected 00000014", imem_addr);
    end
    fetch_instr({16'($urandom), 16'h0008}, 0);
    retire(BR_BNE, JMP_NONE, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_jump;
    jump_to(32'h1000_0040);
    fetch_instr({6'h02, 26'h100}, 0);
    retire(BR_NONE, JMP_J, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h1000_0400) begin
      errors++; $display("FAIL jump_j: imem_addr=%h expected 10000400", imem_addr);
    end
    fetch_instr({16'($urandom), 16'h0004}, 1);
    retire(BR_BEQ, JMP_JR, 1'b1, 32'h87, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h84) begin
      errors++; $display("FAIL jump_jr: imem_addr=%h expected 00000084", imem_addr);
    end
    fetch_instr($urandom, 0);
    retire(BR_BNE, JMP_JAL, 1'b0, $urandom, 1'b0, 32'd0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      fetch_instr($urandom, $urandom_range(0, 3));
      retire(2'($urandom), 2'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 9));
    end
  endtask

  task automatic test_stall;
    logic [31:0] icnt_before;
    fetch_instr($urandom, 1);
    icnt_before = instr_cnt;
    for (int i = 0; i < 5; i++) begin
      branch = 2'($urandom); jump = 2'($urandom); rs_data = $urandom;
      @(negedge clk);
      checks++;
      if (imem_addr !== model_pc || instr !== model_instr || instr_valid !== 1'b1 ||
          imem_req !== 1'b0 || pc_plus4 !== model_pc + 32'd4 || instr_cnt !== icnt_before) begin
        errors++;
        $display("FAIL stall_hold: addr=%h instr=%h valid=%b req=%b icnt=%h expected %h %h 1 0 %h",
                 imem_addr, instr, instr_valid, imem_req, instr_cnt, model_pc, model_instr, icnt_before);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (instr_cnt !== model_retired) begin
      errors++; $display("FAIL instr_cnt: instr_cnt=%h expected %h", instr_cnt, model_retired);
    end
`else
    checks++;
    if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL counters_off: cyc=%h icnt=%h expected 0 0", cycle_cnt, instr_cnt);
    end
`endif
    retire(BR_NONE, JMP_NONE, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_wrap;
    jump_to(32'hFFFF_FFFC);
    fetch_instr($urandom, 0);
    retire(BR_NONE, JMP_NONE, 1'b0, 32'd0, 1'b0, 32'd0);
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL pc_wrap: imem_addr=%h expected 00000000", imem_addr);
    end
  endtask

  task automatic test_syscall_continue;
    fetch_instr(32'h0000_000C, 0);
    retire(BR_NONE, JMP_NONE, 1'b0, 32'd0, 1'b1, 32'd4);
  endtask

  task automatic test_reset_mid_fetch;
    jump_to(32'h0000_0200);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'd0) begin
      errors++; $display("FAIL reset_mid_ack: valid=%b instr=%h expected 0 0", instr_valid, instr);
    end
    #2 rst_n = 1'b1;
    model_pc = RESET_PC;
    model_retired = '0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_refetch: req=%b addr=%h valid=%b expected 1 %h 0",
               imem_req, imem_addr, instr_valid, RESET_PC);
    end
    fetch_instr($urandom, 2);
    retire(BR_NONE, JMP_NONE, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_halt;
    logic [31:0] cyc_frozen;
    fetch_instr(32'h0000_000C, 1);
    retire(BR_NONE, JMP_NONE, 1'b0, 32'd0, 1'b1, HALT_CODE);
    cyc_frozen = cycle_cnt;
    stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          imem_addr !== model_pc || cycle_cnt !== cyc_frozen) begin
        errors++;
        $display("FAIL halt_hold: halted=%b req=%b valid=%b addr=%h cyc=%h expected 1 0 0 %h %h",
                 halted, imem_req, instr_valid, imem_addr, cycle_cnt, model_pc, cyc_frozen);
      end
    end
    imem_ack = 1'b0;
    stall = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (instr_cnt !== model_retired || cycle_cnt === 32'd0) begin
      errors++; $display("FAIL halt_counts: icnt=%h cyc=%h expected icnt=%h cyc>0",
                         instr_cnt, cycle_cnt, model_retired);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b1;
    branch = 2'b00; jump = 2'b00; syscall_src = 1'b0; alu_zero = 1'b0;
    rs_data = '0; v0_data = '0;
    model_pc = RESET_PC; model_instr = '0; model_retired = '0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump();
    test_random();
    test_stall();
    test_wrap();
    test_syscall_continue();
    test_reset_mid_fetch();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
